// File: rtl/radix4_booth_divider_if.sv
// rtl/radix4_booth_divider_if.sv - start/done handshake and result bundle for the radix-4 divider
interface radix4_booth_divider_if #(parameter int N = 16);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] Quot;
  logic [N-1:0] Rem;
  logic         div_by_zero;
  logic         ovf;

  modport master (output start, a, b,
                  input  busy, done, Quot, Rem, div_by_zero, ovf);
  modport slave  (input  start, a, b,
                  output busy, done, Quot, Rem, div_by_zero, ovf);
endinterface

// File: rtl/radix4_booth_divider.sv
// rtl/radix4_booth_divider.sv - fixed-latency signed divider, 2 quotient bits per cycle on magnitudes
module radix4_booth_divider #(
  parameter int N = 16
) (
  input logic                   clk,
  input logic                   rst,
  radix4_booth_divider_if.slave bus
);
  localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_r, b_r;
  logic [N-1:0]   rq;
  logic [N+1:0]   p, d1, d2, d3;
  logic [N+1:0]   sh, sub;
  logic [1:0]     digit;
  logic [CW-1:0]  cnt;
  logic           sign_q, sign_r;
  logic [N-1:0]   mag_a, mag_b;
  logic [N-1:0]   quot_r, rem_r;
  logic           done_r, dz_r, ovf_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ITER) || (state == FIX);
  end

  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude
  assign mag_a = a_r[N-1] ? -a_r : a_r;
  assign mag_b = b_r[N-1] ? -b_r : b_r;

  // P < |b| holds between steps, so the shifted value is below 4|b| and one digit always suffices
  always_comb begin
    sh = (p << 2) | {{N{1'b0}}, rq[N-1:N-2]};
    if (sh >= d3) begin
      digit = 2'd3;
      sub   = d3;
    end else if (sh >= d2) begin
      digit = 2'd2;
      sub   = d2;
    end else if (sh >= d1) begin
      digit = 2'd1;
      sub   = d1;
    end else begin
      digit = 2'd0;
      sub   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      rq     <= '0;
      p      <= '0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        PREP: begin
          rq     <= mag_a;
          p      <= '0;
          d1     <= {2'b00, mag_b};
          d2     <= {1'b0, mag_b, 1'b0};
          d3     <= {2'b00, mag_b} + {1'b0, mag_b, 1'b0};
          sign_q <= a_r[N-1] ^ b_r[N-1];
          sign_r <= a_r[N-1];
          cnt    <= CW'(N / 2 - 1);
        end
        ITER: begin
          p   <= sh - sub;
          rq  <= {rq[N-3:0], digit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // with b=0 every compare passes, leaving Rem=|a|; only Quot needs forcing
          quot_r <= (b_r == '0) ? '1 : (sign_q ? -rq : rq);
          rem_r  <= sign_r ? -p[N-1:0] : p[N-1:0];
          dz_r   <= (b_r == '0);
          ovf_r  <= (a_r == {1'b1, {(N-1){1'b0}}}) && (b_r == '1);
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = done_r;
  assign bus.Quot        = quot_r;
  assign bus.Rem         = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.ovf         = ovf_r;
endmodule
